// File: rtl/intr_sched.sv
`default_nettype none
// ============================================================================
// Module   : intr_sched
// Purpose  : Interrupt scheduler. It captures rising edges on the source lines
//            into per-source pending flags and masks them. It arbitrates one
//            winner and runs a request/acknowledge/return-from-interrupt
//            handshake with the CPU. Interrupts do not nest: SERVICE blocks any
//            new request until rti.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk       system clock, rising edge
//            rst_n     synchronous active-low reset
//            irq_in    raw source lines (rising edge = event)
//            mask_ld   load mask_in into the mask register
//            mask_in   source enables (1 = enabled)
//            intr_en   CPU global interrupt enable
//            intr_ack  CPU accepts current request (pulse)
//            rti       CPU return-from-interrupt (pulse)
//            intr_out  interrupt request to the CPU
//            vec_out   index of the granted source
//            pend_out  pending flags (status readback)
//            busy      high while the CPU services an interrupt
// Options  : INTR_SCHED_RR_EN - round-robin arbitration starting after the
//            last granted source. Undefined: lowest index wins.
// ============================================================================
module intr_sched #(
  parameter int N_SRC = 4,
  parameter int VEC_W = $clog2(N_SRC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             mask_ld,
  input  logic [N_SRC-1:0] mask_in,
  input  logic             intr_en,
  input  logic             intr_ack,
  input  logic             rti,
  output logic             intr_out,
  output logic [VEC_W-1:0] vec_out,
  output logic [N_SRC-1:0] pend_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;
  logic [N_SRC-1:0] mask_q;
  logic [VEC_W-1:0] vec_q;
  logic             intr_q;
  logic             busy_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [VEC_W-1:0] win;

`ifdef INTR_SCHED_RR_EN
  logic [VEC_W-1:0] ptr_q;
`endif

  assign rise = irq_in & ~irq_q;
  assign elig = pend_q & mask_q;

  // Only an accepted request clears its flag. A new edge in the same cycle
  // re-sets it, so the event is not lost.
  always_comb begin
    clr = '0;
    if (state_q == S_REQ && intr_ack) begin
      clr[vec_q] = 1'b1;
    end
    pend_d = (pend_q & ~clr) | rise;
  end

`ifdef INTR_SCHED_RR_EN
  // Scan distances N_SRC down to 1 from the pointer. The last hit is the
  // nearest eligible source after the previous grant.
  always_comb begin
    logic [VEC_W:0] cand;
    win = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (VEC_W+1)'(k);
      if (cand >= (VEC_W+1)'(N_SRC)) begin
        cand = cand - (VEC_W+1)'(N_SRC);
      end
      if (elig[cand[VEC_W-1:0]]) begin
        win = cand[VEC_W-1:0];
      end
    end
  end
`else
  // Descending scan, so the lowest eligible index is assigned last.
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win = VEC_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      vec_q   <= '0;
      intr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef INTR_SCHED_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      irq_q  <= irq_in;
      pend_q <= pend_d;
      if (mask_ld) begin
        mask_q <= mask_in;
      end
      case (state_q)
        S_IDLE: begin
          if (intr_en && (|elig)) begin
            vec_q   <= win;
            intr_q  <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // The winner stays frozen here. An acknowledge that coincides with
          // intr_en falling still counts, because the CPU has taken it.
          if (intr_ack) begin
            intr_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SERVICE;
`ifdef INTR_SCHED_RR_EN
            ptr_q   <= vec_q;
`endif
          end else if (!intr_en) begin
            intr_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (rti) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          intr_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign intr_out = intr_q;
  assign vec_out  = vec_q;
  assign pend_out = pend_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_intr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_intr_sched
// Purpose  : Directed testbench for intr_sched in the default configuration
//            (fixed priority, N_SRC = 4). Inputs change 1 ns after each rising
//            edge. Outputs are sampled at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] irq_in;
  logic       mask_ld;
  logic [3:0] mask_in;
  logic       intr_en;
  logic       intr_ack;
  logic       rti;
  logic       intr_out;
  logic [1:0] vec_out;
  logic [3:0] pend_out;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  intr_sched #(.N_SRC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .irq_in   (irq_in),
    .mask_ld  (mask_ld),
    .mask_in  (mask_in),
    .intr_en  (intr_en),
    .intr_ack (intr_ack),
    .rti      (rti),
    .intr_out (intr_out),
    .vec_out  (vec_out),
    .pend_out (pend_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; irq_in = 4'b0000; mask_ld = 1'b0; mask_in = 4'b0000;
    intr_en = 1'b1; intr_ack = 1'b0; rti = 1'b0;
    tick; tick;
    check("rst_pend", 16'(pend_out), 16'h0);
    check("rst_intr", 16'(intr_out), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_vec", 16'(vec_out), 16'h0);
    rst_n = 1'b1;
    tick;

    // Single event on bit 2 (reset mask is all ones)
    irq_in = 4'b0100; tick;
    check("t1_pend", 16'(pend_out), 16'h4);
    check("t1_intr_early", 16'(intr_out), 16'h0);
    irq_in = 4'b0000; tick;
    check("t1_intr", 16'(intr_out), 16'h1);
    check("t1_vec", 16'(vec_out), 16'h2);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t1_ack_pend", 16'(pend_out), 16'h0);
    check("t1_ack_busy", 16'(busy), 16'h1);
    check("t1_ack_intr", 16'(intr_out), 16'h0);
    rti = 1'b1; tick; rti = 1'b0;
    check("t1_rti_busy", 16'(busy), 16'h0);
    tick;
    check("t1_idle_intr", 16'(intr_out), 16'h0);

    // Simultaneous events on bits 1 and 3
    irq_in = 4'b1010; tick; irq_in = 4'b0000;
    check("t2_pend", 16'(pend_out), 16'hA);
    tick;
    check("t2_intr", 16'(intr_out), 16'h1);
    check("t2_vec", 16'(vec_out), 16'h1);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t2_ack_pend", 16'(pend_out), 16'h8);
    tick;
    check("t2_no_nest", 16'(intr_out), 16'h0);
    check("t2_svc_busy", 16'(busy), 16'h1);
    rti = 1'b1; tick; rti = 1'b0;
    check("t2_gap_intr", 16'(intr_out), 16'h0);
    check("t2_gap_busy", 16'(busy), 16'h0);
    tick;
    check("t2_req2_intr", 16'(intr_out), 16'h1);
    check("t2_req2_vec", 16'(vec_out), 16'h3);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t2_ack2_pend", 16'(pend_out), 16'h0);
    rti = 1'b1; tick; rti = 1'b0;

    // Masked source stays pending and fires when unmasked
    mask_ld = 1'b1; mask_in = 4'b1110; irq_in = 4'b0001; tick;
    mask_ld = 1'b0; irq_in = 4'b0000; tick; tick;
    check("t3_masked_intr", 16'(intr_out), 16'h0);
    check("t3_masked_pend", 16'(pend_out), 16'h1);
    mask_ld = 1'b1; mask_in = 4'b1111; tick; mask_ld = 1'b0;
    check("t3_unmask_edge", 16'(intr_out), 16'h0);
    tick;
    check("t3_intr", 16'(intr_out), 16'h1);
    check("t3_vec", 16'(vec_out), 16'h0);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t3_ack_pend", 16'(pend_out), 16'h0);
    rti = 1'b1; tick; rti = 1'b0;

    // A new edge in the ack cycle: set wins over clear
    irq_in = 4'b0100; tick; irq_in = 4'b0000; tick;
    check("t4_vec", 16'(vec_out), 16'h2);
    intr_ack = 1'b1; irq_in = 4'b0100; tick; intr_ack = 1'b0; irq_in = 4'b0000;
    check("t4_pend_kept", 16'(pend_out), 16'h4);
    check("t4_busy", 16'(busy), 16'h1);
    rti = 1'b1; tick; rti = 1'b0;
    check("t4_gap_intr", 16'(intr_out), 16'h0);
    tick;
    check("t4_rereq_intr", 16'(intr_out), 16'h1);
    check("t4_rereq_vec", 16'(vec_out), 16'h2);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    rti = 1'b1; tick; rti = 1'b0;

    // intr_en drop in REQ, stray ack, frozen winner
    irq_in = 4'b0010; tick; irq_in = 4'b0000; tick;
    check("t5_intr", 16'(intr_out), 16'h1);
    intr_en = 1'b0; tick;
    check("t5_drop_intr", 16'(intr_out), 16'h0);
    check("t5_drop_pend", 16'(pend_out), 16'h2);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t5_stray_ack_pend", 16'(pend_out), 16'h2);
    check("t5_stray_ack_busy", 16'(busy), 16'h0);
    intr_en = 1'b1; tick;
    check("t5_reen_intr", 16'(intr_out), 16'h1);
    check("t5_reen_vec", 16'(vec_out), 16'h1);
    irq_in = 4'b0001; tick; irq_in = 4'b0000;
    check("t5_frozen_vec", 16'(vec_out), 16'h1);
    check("t5_frozen_pend", 16'(pend_out), 16'h3);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t5_ack_pend", 16'(pend_out), 16'h1);
    rti = 1'b1; tick; rti = 1'b0; tick;
    check("t5_next_vec", 16'(vec_out), 16'h0);
    check("t5_next_intr", 16'(intr_out), 16'h1);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    rti = 1'b1; tick; rti = 1'b0;

    // Reset during SERVICE, then a line held high through reset
    irq_in = 4'b1010; tick; irq_in = 4'b0000; tick;
    intr_ack = 1'b1; irq_in = 4'b0010; tick; intr_ack = 1'b0; irq_in = 4'b0000;
    check("t6_svc_pend", 16'(pend_out), 16'hA);
    check("t6_svc_busy", 16'(busy), 16'h1);
    irq_in = 4'b0001; rst_n = 1'b0; tick;
    check("t6_rst_busy", 16'(busy), 16'h0);
    check("t6_rst_pend", 16'(pend_out), 16'h0);
    check("t6_rst_intr", 16'(intr_out), 16'h0);
    check("t6_rst_vec", 16'(vec_out), 16'h0);
    tick;
    check("t6_rst_hold_pend", 16'(pend_out), 16'h0);
    rst_n = 1'b1; tick;
    check("t6_post_rst_pend", 16'(pend_out), 16'h1);
    check("t6_post_rst_intr", 16'(intr_out), 16'h0);
    tick;
    check("t6_post_rst_req", 16'(intr_out), 16'h1);
    check("t6_post_rst_vec", 16'(vec_out), 16'h0);
    intr_ack = 1'b1; tick; intr_ack = 1'b0;
    check("t6_level_no_rise", 16'(pend_out), 16'h0);
    irq_in = 4'b0000; rti = 1'b1; tick; rti = 1'b0;
    check("t6_rti_busy", 16'(busy), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
